// File: rtl/exec_ctrl.sv
// Four-state instruction sequencer: READ, EXEC, WB on a 6-bit signed register file.
// Define EXEC_CTRL_SAT_EN to saturate ADD/SUB/NEG results on overflow; without it they wrap.
module exec_ctrl #(
   parameter int DATA_W = 6
) (
   input  logic                     i_clk,
   input  logic                     i_rsn,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic [2:0]               i_op,
   input  logic [3:0]               i_src0,
   input  logic [3:0]               i_src1,
   input  logic [3:0]               i_dst,
   output logic [3:0]               o_reg0,
   output logic [3:0]               o_reg1,
   input  logic signed [DATA_W-1:0] i_data0,
   input  logic signed [DATA_W-1:0] i_data1,
   output logic [3:0]               o_reg2,
   output logic signed [DATA_W-1:0] o_data2,
   output logic                     o_done,
   output logic                     o_ovf
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NEG = 3'b101;
   localparam logic [2:0] OP_MOV = 3'b110;
   localparam logic [2:0] OP_NOP = 3'b111;

   localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

   // Overflow shows up as disagreement between the two top bits of the widened result.
   function automatic logic signed [DATA_W-1:0] fit(input logic signed [DATA_W:0] wide);
`ifdef EXEC_CTRL_SAT_EN
      if (wide[DATA_W] != wide[DATA_W-1])
         fit = wide[DATA_W] ? MIN_V : MAX_V;
      else
         fit = wide[DATA_W-1:0];
`else
      fit = wide[DATA_W-1:0];
`endif
   endfunction

   state_t r_state, w_next;

   logic [2:0]               r_op_p0;
   logic [3:0]               r_src0_p0, r_src1_p0, r_dst_p0;
   logic signed [DATA_W-1:0] r_a_p1, r_b_p1;
   logic signed [DATA_W-1:0] r_res_p2;
   logic                     r_ovf_p2;

   logic signed [DATA_W:0]   w_ax, w_bx, w_wide;
   logic signed [DATA_W-1:0] w_res;
   logic                     w_arith, w_ovf, w_wr_en;

   always_ff @(posedge i_clk or negedge i_rsn) begin
      if (!i_rsn) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_valid) w_next = S_READ;
         S_READ:  w_next = S_EXEC;
         S_EXEC:  w_next = S_WB;
         default: w_next = S_IDLE;
      endcase
   end

   // Accept: latch the instruction fields
   always_ff @(posedge i_clk or negedge i_rsn) begin
      if (!i_rsn) begin
         r_op_p0   <= OP_NOP;
         r_src0_p0 <= '0;
         r_src1_p0 <= '0;
         r_dst_p0  <= '0;
      end else if (r_state == S_IDLE && i_valid) begin
         r_op_p0   <= i_op;
         r_src0_p0 <= i_src0;
         r_src1_p0 <= i_src1;
         r_dst_p0  <= i_dst;
      end
   end

   // READ -> EXEC: capture operands
   always_ff @(posedge i_clk or negedge i_rsn) begin
      if (!i_rsn) begin
         r_a_p1 <= '0;
         r_b_p1 <= '0;
      end else if (r_state == S_READ) begin
         r_a_p1 <= i_data0;
         r_b_p1 <= i_data1;
      end
   end

   always_comb begin
      w_ax    = {r_a_p1[DATA_W-1], r_a_p1};
      w_bx    = {r_b_p1[DATA_W-1], r_b_p1};
      w_wide  = '0;
      w_arith = 1'b0;
      w_res   = '0;
      case (r_op_p0)
         OP_ADD:  begin w_wide = w_ax + w_bx; w_arith = 1'b1; end
         OP_SUB:  begin w_wide = w_ax - w_bx; w_arith = 1'b1; end
         OP_NEG:  begin w_wide = -w_ax;       w_arith = 1'b1; end
         OP_AND:  w_res = r_a_p1 & r_b_p1;
         OP_OR:   w_res = r_a_p1 | r_b_p1;
         OP_XOR:  w_res = r_a_p1 ^ r_b_p1;
         OP_MOV:  w_res = r_a_p1;
         default: w_res = '0;
      endcase
      w_ovf = w_arith && (w_wide[DATA_W] != w_wide[DATA_W-1]);
      if (w_arith) w_res = fit(w_wide);
   end

   // EXEC -> WB: register result and overflow
   always_ff @(posedge i_clk or negedge i_rsn) begin
      if (!i_rsn) begin
         r_res_p2 <= '0;
         r_ovf_p2 <= 1'b0;
      end else if (r_state == S_EXEC) begin
         r_res_p2 <= w_res;
         r_ovf_p2 <= w_ovf;
      end
   end

   // Only R1..R11 are writable; NOP never writes.
   assign w_wr_en = (r_dst_p0 != 4'd0) && (r_dst_p0 <= 4'd11) && (r_op_p0 != OP_NOP);

   assign o_ready = (r_state == S_IDLE);
   assign o_reg0  = (r_state == S_READ) ? r_src0_p0 : 4'd0;
   assign o_reg1  = (r_state == S_READ) ? r_src1_p0 : 4'd0;
   assign o_reg2  = (r_state == S_WB && w_wr_en) ? r_dst_p0 : 4'd0;
   assign o_data2 = (r_state == S_WB) ? r_res_p2 : '0;
   assign o_done  = (r_state == S_WB);
   assign o_ovf   = r_ovf_p2;

endmodule
